// File: rtl/study_pkg.sv
// Shared types and constants for the study-mode note sequencer.
package study_pkg;

    localparam int unsigned NOTE_W = 10;
    localparam int unsigned ADDR_W = 8;

    localparam logic [NOTE_W-1:0] NO_KEY  = '0;
    localparam logic [7:0]        ERR_MAX = 8'd255;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        LATCH    = 3'd2,
        WAIT_REL = 3'd3,
        WAIT_KEY = 3'd4,
        DONE     = 3'd5
    } state_e;

endpackage

// File: rtl/study_mode_sequencer_key_press_detect.sv
// Edge detector for the debounced key bus: press fires only on a transition out of all-zero.
module key_press_detect
    import study_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NOTE_W-1:0] key_in,
    output logic              press,
    output logic              released
);

    logic [NOTE_W-1:0] key_q;
    logic [NOTE_W-1:0] key_d;

    always_comb begin
        key_d = key_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q <= NO_KEY;
        end else begin
            key_q <= key_d;
        end
    end

    // A key that changes while held keeps key_q non-zero, so it never re-fires.
    assign press    = (key_in != NO_KEY) && (key_q == NO_KEY);
    assign released = (key_in == NO_KEY);

endmodule

// File: rtl/study_mode_sequencer.sv
// Study-mode sequencer: walks the song ROM, publishes the expected note, advances on correct presses.
// Optional idle hint timer is built only when STUDY_TIMEOUT_EN is defined.
module study_mode_sequencer
    import study_pkg::*;
`ifdef STUDY_TIMEOUT_EN
#(
    parameter logic [31:0] TIMEOUT_CYC = 32'd100_000_000
)
`endif
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] song_len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_data,
    input  logic [NOTE_W-1:0] key_in,
    output logic [ADDR_W-1:0] index,
    output logic [NOTE_W-1:0] expect_note,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_cnt,
    output logic              hint
);

    state_e            state_q,    state_d;
    logic [ADDR_W-1:0] index_q,    index_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [NOTE_W-1:0] expect_q,   expect_d;
    logic [7:0]        err_q,      err_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic [ADDR_W-1:0] idx_inc;
    logic              press;
    logic              released;

    key_press_detect u_kpd (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .press    (press),
        .released (released)
    );

    // Next-state and datapath; start overrides everything, including a same-cycle correct press.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        rom_addr_d = rom_addr_q;
        expect_d   = expect_q;
        err_d      = err_q;
        idx_inc    = index_q + ADDR_W'(1);

        if (start) begin
            index_d = '0;
            err_d   = 8'd0;
            state_d = (song_len == '0) ? DONE : FETCH;
        end else begin
            unique case (state_q)
                IDLE:     state_d = IDLE;
                FETCH:    state_d = LATCH;
                LATCH: begin
                    expect_d = rom_data;
                    state_d  = (rom_data == NO_KEY) ? DONE : WAIT_REL;
                end
                WAIT_REL: if (released) state_d = WAIT_KEY;
                WAIT_KEY: begin
                    if (press) begin
                        if (key_in == expect_q) begin
                            index_d = idx_inc;
                            // Last addressable slot ends the song even without an end marker.
                            state_d = ((idx_inc == song_len) || (idx_inc == '1)) ? DONE : FETCH;
                        end else if (err_q != ERR_MAX) begin
                            err_d = err_q + 8'd1;
                        end
                    end
                end
                DONE:     state_d = DONE;
                default:  state_d = IDLE;
            endcase
        end

        if (state_d == FETCH) begin
            rom_addr_d = index_d;
        end
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            index_q    <= '0;
            rom_addr_q <= '0;
            expect_q   <= NO_KEY;
            err_q      <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            rom_addr_q <= rom_addr_d;
            expect_q   <= expect_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef STUDY_TIMEOUT_EN
    logic [31:0] to_q, to_d;
    logic        hint_q, hint_d;

    // Idle timer counts only while sitting in WAIT_KEY; any press or state change clears it and the hint.
    always_comb begin
        to_d   = 32'd0;
        hint_d = 1'b0;
        if (!start && (state_q == WAIT_KEY) && (state_d == WAIT_KEY) && !press) begin
            to_d   = (to_q == TIMEOUT_CYC) ? to_q : to_q + 32'd1;
            hint_d = hint_q | (to_d == TIMEOUT_CYC);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_q   <= 32'd0;
            hint_q <= 1'b0;
        end else begin
            to_q   <= to_d;
            hint_q <= hint_d;
        end
    end

    assign hint = hint_q;
`else
    assign hint = 1'b0;
`endif

    assign rom_addr    = rom_addr_q;
    assign index       = index_q;
    assign expect_note = expect_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_study_mode_sequencer.sv
// Directed bench for study_mode_sequencer; hint checks adapt to STUDY_TIMEOUT_EN (TIMEOUT_CYC=20).
module tb_study_mode_sequencer;
    import study_pkg::*;

    localparam logic [NOTE_W-1:0] N_C = 10'd1;
    localparam logic [NOTE_W-1:0] N_D = 10'd2;
    localparam logic [NOTE_W-1:0] N_E = 10'd4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] song_len;
    logic [ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0] rom_data;
    logic [NOTE_W-1:0] key_in;
    logic [ADDR_W-1:0] index;
    logic [NOTE_W-1:0] expect_note;
    logic              busy;
    logic              done;
    logic [7:0]        err_cnt;
    logic              dut_hint;

    logic [NOTE_W-1:0] rom [256];
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address.
    always_ff @(posedge clk) rom_data <= rom[rom_addr];

`ifdef STUDY_TIMEOUT_EN
    study_mode_sequencer #(.TIMEOUT_CYC(32'd20)) dut (
`else
    study_mode_sequencer dut (
`endif
        .clk(clk), .rst(rst), .start(start), .song_len(song_len),
        .rom_addr(rom_addr), .rom_data(rom_data), .key_in(key_in),
        .index(index), .expect_note(expect_note), .busy(busy), .done(done),
        .err_cnt(err_cnt), .hint(dut_hint)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rom(input logic [NOTE_W-1:0] n0, input logic [NOTE_W-1:0] n1,
                            input logic [NOTE_W-1:0] n2, input logic [NOTE_W-1:0] n3,
                            input logic [NOTE_W-1:0] n4);
        for (int i = 0; i < 256; i++) rom[i] = NO_KEY;
        rom[0] = n0; rom[1] = n1; rom[2] = n2; rom[3] = n3; rom[4] = n4;
    endtask

    // start pulse, then FETCH, LATCH, WAIT_REL -> WAIT_KEY with no key held
    task automatic begin_song();
        start  = 1'b1;
        key_in = NO_KEY;
        tick();
        start = 1'b0;
        repeat (3) tick();
    endtask

    task automatic press(input logic [NOTE_W-1:0] n);
        key_in = n;
        tick();
    endtask

    task automatic release_settle();
        key_in = NO_KEY;
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; key_in = NO_KEY; song_len = '0;
        load_rom(N_C, N_D, N_E, NO_KEY, NO_KEY);
        #12;
        check("rst_index",  32'(index), 32'd0);
        check("rst_addr",   32'(rom_addr), 32'd0);
        check("rst_expect", 32'(expect_note), 32'd0);
        check("rst_err",    32'(err_cnt), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_hint",   32'(dut_hint), 32'd0);
        rst = 1'b1;
        tick();

        // Song {C,D,E}, len 3
        song_len = 8'd3;
        start = 1'b1; tick(); start = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_idx0", 32'(index), 32'd0);
        repeat (2) tick();
        check("t1_expC", 32'(expect_note), 32'(N_C));
        tick();
        press(N_C);  check("t1_idx1", 32'(index), 32'd1);
        release_settle();
        check("t1_expD", 32'(expect_note), 32'(N_D));
        press(N_D);  check("t1_idx2", 32'(index), 32'd2);
        release_settle();
        press(N_E);
        check("t1_idx3", 32'(index), 32'd3);
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy0", 32'(busy), 32'd0);
        check("t1_err", 32'(err_cnt), 32'd0);
        release_settle();
        check("t1_hold", 32'(done), 32'd1);

        // Wrong presses counted once each, including a key changed while held
        begin_song();
        press(N_D);  check("t2_err1", 32'(err_cnt), 32'd1);
        press(N_E);  check("t2_slide", 32'(err_cnt), 32'd1);
        key_in = NO_KEY; tick();
        press(N_E);  check("t2_err2", 32'(err_cnt), 32'd2);
        check("t2_noadv", 32'(index), 32'd0);
        key_in = NO_KEY; tick();
        press(N_C);  check("t2_idx1", 32'(index), 32'd1);
        check("t2_errkeep", 32'(err_cnt), 32'd2);
        release_settle();
        press(N_D);  check("t5_idx2", 32'(index), 32'd2);
        release_settle();
        // start together with the correct press: start wins
        start = 1'b1; key_in = N_E; tick(); start = 1'b0; key_in = NO_KEY;
        check("t5_idx0", 32'(index), 32'd0);
        check("t5_err0", 32'(err_cnt), 32'd0);
        check("t5_addr", 32'(rom_addr), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_done", 32'(done), 32'd0);

        // Song {C,C}: held key must not double-advance
        load_rom(N_C, N_C, NO_KEY, NO_KEY, NO_KEY);
        song_len = 8'd2;
        begin_song();
        press(N_C);
        repeat (50) tick();
        check("t3_held_idx", 32'(index), 32'd1);
        check("t3_held_done", 32'(done), 32'd0);
        key_in = NO_KEY; tick();
        press(N_C);
        check("t3_idx2", 32'(index), 32'd2);
        check("t3_done", 32'(done), 32'd1);
        key_in = NO_KEY; tick();

        // End marker at addr 2 with song_len 5
        load_rom(N_C, N_D, NO_KEY, N_E, N_E);
        song_len = 8'd5;
        begin_song();
        press(N_C); release_settle();
        press(N_D); key_in = NO_KEY;
        check("t4_busy", 32'(busy), 32'd1);
        repeat (2) tick();
        check("t4_done", 32'(done), 32'd1);
        check("t4_idx", 32'(index), 32'd2);
        check("t4_busy0", 32'(busy), 32'd0);
        // Empty song
        song_len = 8'd0;
        start = 1'b1; tick(); start = 1'b0;
        check("t4_empty_done", 32'(done), 32'd1);
        check("t4_empty_busy", 32'(busy), 32'd0);
        check("t4_empty_idx", 32'(index), 32'd0);

        // Idle hint in WAIT_KEY
        load_rom(N_C, N_D, NO_KEY, NO_KEY, NO_KEY);
        song_len = 8'd2;
        begin_song();
        repeat (19) tick();
        check("t6_hint19", 32'(dut_hint), 32'd0);
        tick();
`ifdef STUDY_TIMEOUT_EN
        check("t6_hint20", 32'(dut_hint), 32'd1);
`else
        check("t6_hint20", 32'(dut_hint), 32'd0);
`endif
        press(N_D);
        check("t6_hint_clr", 32'(dut_hint), 32'd0);
        check("t6_err", 32'(err_cnt), 32'd1);
        key_in = NO_KEY; tick();
        press(N_C);
        check("t6_idx", 32'(index), 32'd1);

        // Asynchronous reset mid-song
        #3 rst = 1'b0;
        #1;
        check("t5r_index", 32'(index), 32'd0);
        check("t5r_err", 32'(err_cnt), 32'd0);
        check("t5r_addr", 32'(rom_addr), 32'd0);
        check("t5r_expect", 32'(expect_note), 32'd0);
        check("t5r_busy", 32'(busy), 32'd0);
        check("t5r_done", 32'(done), 32'd0);
        check("t5r_hint", 32'(dut_hint), 32'd0);
        key_in = NO_KEY;
        #10 rst = 1'b1;
        repeat (3) tick();
        check("t5r_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
